dmem_arbiter: RTL and testbench

- Sits between the CPU load/store unit and the four byte-wide data memory banks (bank i holds byte lane i of each 32-bit word). An auxiliary requester (loader/debug port) shares the same banks.
- Arbitrates between the two requesters each cycle and generates per-lane read/write strobes from byte address and access size.
- Realigns and sign/zero-extends read data for LB/LH/LW/LBU/LHU, and flags misaligned accesses.

---
 rtl/dmem_pkg.sv | 51 +++++
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_load_align.sv | 36 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter and the load realignment path.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_AUX = 1'b1
  } owner_e;

  // Everything the response stage needs to know about the access issued last cycle
  typedef struct packed {
    owner_e     owner;
    logic [1:0] off;
    size_e      size;
    logic       uns;
    logic       we;
    logic       err;
    logic       valid;
  } resp_tag_t;

  // Encoding 3 on the request bus is treated as a full word
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'd0:    return SZ_B;
      2'd1:    return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 1'b0;
      SZ_H:    return off[0];
      default: return off != 2'd0;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input size_e sz, input logic [1:0] off);
    case (sz)
      SZ_B:    return 4'b0001 << off;
      SZ_H:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bundle for the CPU and aux requesters plus the four byte banks.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [1:0]        cpu_size;
  logic              cpu_unsigned;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;
  logic              cpu_err;

  logic              aux_req;
  logic              aux_we;
  logic [ADDR_W-1:0] aux_addr;
  logic [31:0]       aux_wdata;
  logic              aux_gnt;
  logic              aux_rvalid;
  logic [31:0]       aux_rdata;

  logic [ADDR_W-3:0] bank_addr;
  logic [3:0]        bank_re;
  logic [3:0]        bank_we;
  logic [31:0]       bank_wdata;
  logic [31:0]       bank_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    input  aux_req, aux_we, aux_addr, aux_wdata,
    output aux_gnt, aux_rvalid, aux_rdata,
    output bank_addr, bank_re, bank_we, bank_wdata,
    input  bank_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_size, cpu_unsigned, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_err,
    output aux_req, aux_we, aux_addr, aux_wdata,
    input  aux_gnt, aux_rvalid, aux_rdata,
    input  bank_addr, bank_re, bank_we, bank_wdata,
    output bank_rdata
  );

endinterface

// File: rtl/dmem_load_align.sv
// Picks the addressed byte/half out of a bank word and sign- or zero-extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off_i)
      2'd0: byte_sel = rdata_i[7:0];
      2'd1: byte_sel = rdata_i[15:8];
      2'd2: byte_sel = rdata_i[23:16];
      2'd3: byte_sel = rdata_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    data_o = rdata_i;
    case (size_i)
      SZ_B:    data_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the byte-banked data memory with starvation guard,
// lane strobe generation and a one-deep response pipeline.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_LIM = 4
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  logic [3:0]  starve_q, starve_d;
  resp_tag_t   resp_q, resp_d;

  size_e       cpu_size;
  logic [1:0]  cpu_off;
  logic        cpu_mis;
  logic        aux_force;
  logic        cpu_gnt;
  logic        aux_gnt;
  logic [3:0]  cpu_lanes;
  logic [31:0] cpu_wdata_rep;
  logic [31:0] load_data;
  logic        cpu_v;
  logic        aux_v;
  logic        unused_aux_off;

  assign cpu_size  = decode_size(bus.cpu_size);
  assign cpu_off   = bus.cpu_addr[1:0];
  assign cpu_mis   = misaligned(cpu_size, cpu_off);
  assign cpu_lanes = cpu_mis ? 4'b0000 : lane_mask(cpu_size, cpu_off);

  // Aux only overrides a competing CPU request once the guard has tripped
  assign aux_force = bus.aux_req && (starve_q == STARVE_MAX);
  assign cpu_gnt   = bus.cpu_req && !aux_force;
  assign aux_gnt   = bus.aux_req && !cpu_gnt;

  assign bus.cpu_gnt = cpu_gnt;
  assign bus.aux_gnt = aux_gnt;

  // Aux is word-only; its low address bits carry no meaning
  assign unused_aux_off = ^bus.aux_addr[1:0];

  always_comb begin
    case (cpu_size)
      SZ_B:    cpu_wdata_rep = {4{bus.cpu_wdata[7:0]}};
      SZ_H:    cpu_wdata_rep = {2{bus.cpu_wdata[15:0]}};
      default: cpu_wdata_rep = bus.cpu_wdata;
    endcase
  end

  always_comb begin
    bus.bank_addr  = '0;
    bus.bank_wdata = '0;
    bus.bank_re    = 4'b0000;
    bus.bank_we    = 4'b0000;
    if (cpu_gnt) begin
      bus.bank_addr  = bus.cpu_addr[ADDR_W-1:2];
      bus.bank_wdata = cpu_wdata_rep;
      if (bus.cpu_we) bus.bank_we = cpu_lanes;
      else            bus.bank_re = cpu_lanes;
    end else if (aux_gnt) begin
      bus.bank_addr  = bus.aux_addr[ADDR_W-1:2];
      bus.bank_wdata = bus.aux_wdata;
      if (bus.aux_we) bus.bank_we = 4'b1111;
      else            bus.bank_re = 4'b1111;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.aux_req || aux_gnt) begin
      starve_d = 4'd0;
    end else if (cpu_gnt && starve_q != STARVE_MAX) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_comb begin
    resp_d       = '0;
    resp_d.valid = cpu_gnt | aux_gnt;
    if (cpu_gnt) begin
      resp_d.owner = OWN_CPU;
      resp_d.off   = cpu_off;
      resp_d.size  = cpu_size;
      resp_d.uns   = bus.cpu_unsigned;
      resp_d.we    = bus.cpu_we;
      resp_d.err   = cpu_mis;
    end else if (aux_gnt) begin
      resp_d.owner = OWN_AUX;
      resp_d.size  = SZ_W;
      resp_d.we    = bus.aux_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= 4'd0;
      resp_q   <= '0;
    end else begin
      starve_q <= starve_d;
      resp_q   <= resp_d;
    end
  end

  dmem_load_align u_align (
    .rdata_i (bus.bank_rdata),
    .off_i   (resp_q.off),
    .size_i  (resp_q.size),
    .uns_i   (resp_q.uns),
    .data_o  (load_data)
  );

  assign cpu_v = resp_q.valid && (resp_q.owner == OWN_CPU);
  assign aux_v = resp_q.valid && (resp_q.owner == OWN_AUX);

  // Data is forced to zero for stores, errors and idle cycles
  assign bus.cpu_rvalid = cpu_v;
  assign bus.cpu_err    = cpu_v && resp_q.err;
  assign bus.cpu_rdata  = (cpu_v && !resp_q.err && !resp_q.we) ? load_data : 32'h0;
  assign bus.aux_rvalid = aux_v;
  assign bus.aux_rdata  = (aux_v && !resp_q.we) ? bus.bank_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural four-lane bank model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(16)) bus ();

  dmem_arbiter #(.ADDR_W(16), .STARVE_LIM(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte banks: registered read, write on strobe
  logic [31:0] mem [64];
  always @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (bus.bank_we[l]) mem[bus.bank_addr[5:0]][8*l +: 8] <= bus.bank_wdata[8*l +: 8];
      if (bus.bank_re[l]) bus.bank_rdata[8*l +: 8] <= mem[bus.bank_addr[5:0]][8*l +: 8];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic idle();
    bus.cpu_req      = 1'b0;
    bus.cpu_we       = 1'b0;
    bus.cpu_addr     = '0;
    bus.cpu_size     = 2'd0;
    bus.cpu_unsigned = 1'b0;
    bus.cpu_wdata    = '0;
    bus.aux_req      = 1'b0;
    bus.aux_we       = 1'b0;
    bus.aux_addr     = '0;
    bus.aux_wdata    = '0;
  endtask

  task automatic cpu_drive(input logic we, input logic [15:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] wdata);
    bus.cpu_req      = 1'b1;
    bus.cpu_we       = we;
    bus.cpu_addr     = addr;
    bus.cpu_size     = size;
    bus.cpu_unsigned = uns;
    bus.cpu_wdata    = wdata;
  endtask

  // One isolated CPU access: strobes while requesting, response one cycle later
  task automatic cpu_op(input string tag, input logic we, input logic [15:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input logic [3:0] e_re, input logic [3:0] e_we, input logic [13:0] e_addr,
                        input logic [31:0] e_wd, input logic [31:0] e_rdata, input logic e_err);
    @(negedge clk);
    cpu_drive(we, addr, size, uns, wdata);
    #1;
    chk({tag, ".gnt"},   32'(bus.cpu_gnt), 32'd1);
    chk({tag, ".re"},    32'(bus.bank_re), 32'(e_re));
    chk({tag, ".we"},    32'(bus.bank_we), 32'(e_we));
    chk({tag, ".baddr"}, 32'(bus.bank_addr), 32'(e_addr));
    chk({tag, ".wdata"}, bus.bank_wdata, e_wd);
    @(posedge clk);
    #1;
    chk({tag, ".rvalid"}, 32'(bus.cpu_rvalid), 32'd1);
    chk({tag, ".rdata"},  bus.cpu_rdata, e_rdata);
    chk({tag, ".err"},    32'(bus.cpu_err), 32'(e_err));
    idle();
  endtask

  logic [31:0] exp_b2b [3];
  logic        exp_aux;

  initial begin
    exp_b2b[0] = 32'h11111111;
    exp_b2b[1] = 32'h22222222;
    exp_b2b[2] = 32'h80000008;

    idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst.cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst.aux_rvalid", 32'(bus.aux_rvalid), 32'd0);
    chk("rst.cpu_rdata",  bus.cpu_rdata, 32'h0);
    chk("rst.cpu_err",    32'(bus.cpu_err), 32'd0);
    chk("rst.aux_rdata",  bus.aux_rdata, 32'h0);
    chk("rst.bank_re",    32'(bus.bank_re), 32'd0);
    chk("rst.bank_we",    32'(bus.bank_we), 32'd0);
    rst_n = 1'b1;

    cpu_op("sw10",  1'b1, 16'h0010, 2'd2, 1'b0, 32'hDEADBEEF, 4'h0, 4'hF, 14'h004, 32'hDEADBEEF, 32'h0, 1'b0);
    cpu_op("lw10",  1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 14'h004, 32'h0, 32'hDEADBEEF, 1'b0);
    cpu_op("lb13",  1'b0, 16'h0013, 2'd0, 1'b0, 32'h0, 4'h8, 4'h0, 14'h004, 32'h0, 32'hFFFFFFDE, 1'b0);
    cpu_op("lbu13", 1'b0, 16'h0013, 2'd0, 1'b1, 32'h0, 4'h8, 4'h0, 14'h004, 32'h0, 32'h000000DE, 1'b0);
    cpu_op("lh12",  1'b0, 16'h0012, 2'd1, 1'b0, 32'h0, 4'hC, 4'h0, 14'h004, 32'h0, 32'hFFFFDEAD, 1'b0);
    cpu_op("sb11",  1'b1, 16'h0011, 2'd0, 1'b0, 32'h00000055, 4'h0, 4'h2, 14'h004, 32'h55555555, 32'h0, 1'b0);
    cpu_op("lw10b", 1'b0, 16'h0010, 2'd2, 1'b0, 32'h0, 4'hF, 4'h0, 14'h004, 32'h0, 32'hDEAD55EF, 1'b0);
    cpu_op("lh11",  1'b0, 16'h0011, 2'd1, 1'b0, 32'h0, 4'h0, 4'h0, 14'h004, 32'h0, 32'h0, 1'b1);
    cpu_op("lw12",  1'b0, 16'h0012, 2'd2, 1'b0, 32'h0, 4'h0, 4'h0, 14'h004, 32'h0, 32'h0, 1'b1);
    cpu_op("sh16",  1'b1, 16'h0016, 2'd1, 1'b0, 32'h1234ABCD, 4'h0, 4'hC, 14'h005, 32'hABCDABCD, 32'h0, 1'b0);
    cpu_op("lhu16", 1'b0, 16'h0016, 2'd1, 1'b1, 32'h0, 4'hC, 4'h0, 14'h005, 32'h0, 32'h0000ABCD, 1'b0);
    cpu_op("sw00",  1'b1, 16'h0000, 2'd2, 1'b0, 32'h11111111, 4'h0, 4'hF, 14'h000, 32'h11111111, 32'h0, 1'b0);
    cpu_op("sw04",  1'b1, 16'h0004, 2'd3, 1'b0, 32'h22222222, 4'h0, 4'hF, 14'h001, 32'h22222222, 32'h0, 1'b0);
    cpu_op("sw08",  1'b1, 16'h0008, 2'd2, 1'b0, 32'h80000008, 4'h0, 4'hF, 14'h002, 32'h80000008, 32'h0, 1'b0);

    // Back-to-back loads, one per cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_drive(1'b0, 16'(4 * i), 2'd2, 1'b0, 32'h0);
      #1;
      chk($sformatf("b2b%0d.gnt", i), 32'(bus.cpu_gnt), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("b2b%0d.rvalid", i), 32'(bus.cpu_rvalid), 32'd1);
      chk($sformatf("b2b%0d.rdata", i), bus.cpu_rdata, exp_b2b[i]);
    end
    idle();

    // Aux word store and read back, low address bits ignored
    @(negedge clk);
    bus.aux_req = 1'b1; bus.aux_we = 1'b1; bus.aux_addr = 16'h0020; bus.aux_wdata = 32'hCAFEF00D;
    #1;
    chk("auxw.gnt",   32'(bus.aux_gnt), 32'd1);
    chk("auxw.cgnt",  32'(bus.cpu_gnt), 32'd0);
    chk("auxw.we",    32'(bus.bank_we), 32'hF);
    chk("auxw.baddr", 32'(bus.bank_addr), 32'h008);
    chk("auxw.wdata", bus.bank_wdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    chk("auxw.rvalid", 32'(bus.aux_rvalid), 32'd1);
    chk("auxw.rdata",  bus.aux_rdata, 32'h0);
    chk("auxw.cpu_rv", 32'(bus.cpu_rvalid), 32'd0);
    @(negedge clk);
    bus.aux_we = 1'b0; bus.aux_addr = 16'h0023; bus.aux_wdata = 32'h0;
    #1;
    chk("auxr.re",    32'(bus.bank_re), 32'hF);
    chk("auxr.baddr", 32'(bus.bank_addr), 32'h008);
    @(posedge clk);
    #1;
    chk("auxr.rvalid", 32'(bus.aux_rvalid), 32'd1);
    chk("auxr.rdata",  bus.aux_rdata, 32'hCAFEF00D);
    idle();

    // Both requesting continuously: CPU x4, AUX, repeated
    @(negedge clk);
    cpu_drive(1'b0, 16'h0000, 2'd2, 1'b0, 32'h0);
    bus.aux_req = 1'b1; bus.aux_we = 1'b0; bus.aux_addr = 16'h0007;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      exp_aux = ((k % 5) == 4);
      #1;
      chk($sformatf("starve%0d.cgnt", k), 32'(bus.cpu_gnt), 32'(!exp_aux));
      chk($sformatf("starve%0d.agnt", k), 32'(bus.aux_gnt), 32'(exp_aux));
      @(posedge clk);
      #1;
      chk($sformatf("starve%0d.arv", k), 32'(bus.aux_rvalid), 32'(exp_aux));
      chk($sformatf("starve%0d.crv", k), 32'(bus.cpu_rvalid), 32'(!exp_aux));
      if (exp_aux) chk($sformatf("starve%0d.ard", k), bus.aux_rdata, 32'h22222222);
      else         chk($sformatf("starve%0d.crd", k), bus.cpu_rdata, 32'h11111111);
    end

    // Reset lands on the edge capturing a granted load; counter must restart
    @(negedge clk);
    cpu_drive(1'b0, 16'h0010, 2'd2, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rstld.gnt", 32'(bus.cpu_gnt), 32'd1);
    @(posedge clk);
    #1;
    chk("rstld.cpu_rv", 32'(bus.cpu_rvalid), 32'd0);
    chk("rstld.aux_rv", 32'(bus.aux_rvalid), 32'd0);
    chk("rstld.rdata",  bus.cpu_rdata, 32'h0);
    chk("rstld.err",    32'(bus.cpu_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk($sformatf("post%0d.agnt", k), 32'(bus.aux_gnt), 32'(k == 4));
      @(posedge clk);
    end
    idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
